// File: rtl/mul_node_sched.sv
// Round-robin scheduler that shares one mul_one multiply node among N_REQ requesters.
// It streams the granted requester's operands to the node and returns the tagged product.
module mul_node_sched #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_stb,
    output logic [N_REQ-1:0]        req_ack,
    input  logic [N_REQ*CNT_W-1:0]  req_cnt,
    output logic [DATA_W-1:0]       mul_data,
    output logic                    mul_stb,
    input  logic                    mul_ack,
    output logic [CNT_W-1:0]        mul_cnt_max,
    input  logic [DATA_W-1:0]       mul_z,
    input  logic                    mul_z_stb,
    output logic                    mul_z_ack,
    output logic [DATA_W-1:0]       res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    res_stb,
    input  logic                    res_ack,
    output logic                    busy
);

    localparam logic [DATA_W-1:0] FP_ONE = DATA_W'(32'h3F80_0000);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        WAIT_Z = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [ID_W-1:0]     gnt_r, gnt_s;
    logic [ID_W-1:0]     last_r, last_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [CNT_W-1:0]    k_r, k_s;
    logic [CNT_W-1:0]    cnt_max_r, cnt_max_s;
    logic [DATA_W-1:0]   res_data_r, res_data_s;
    logic [ID_W-1:0]     res_id_r, res_id_s;
    logic                found_s;
    logic [ID_W-1:0]     sel_s;
    logic [CNT_W-1:0]    sel_cnt_s;

    // Round-robin search starting just after the last served requester
    always_comb begin
        found_s   = 1'b0;
        sel_s     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(last_r) + i) % N_REQ;
            if (!found_s && req_stb[idx]) begin
                found_s = 1'b1;
                sel_s   = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        sel_cnt_s = req_cnt[int'(sel_s)*CNT_W +: CNT_W];
    end

    // Next-state logic and the zero-latency operand pass-through while feeding
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        last_s     = last_r;
        cnt_s      = cnt_r;
        k_s        = k_r;
        cnt_max_s  = cnt_max_r;
        res_data_s = res_data_r;
        res_id_s   = res_id_r;
        mul_data   = '0;
        mul_stb    = 1'b0;
        req_ack    = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_s     = sel_s;
                    cnt_s     = sel_cnt_s;
                    cnt_max_s = sel_cnt_s;
                    k_s       = '0;
                    if (sel_cnt_s != '0) begin
                        state_s = FEED;
                    end else begin
                        // Empty product: answer 1.0 without touching the multiplier
                        res_data_s = FP_ONE;
                        res_id_s   = sel_s;
                        state_s    = OUT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FEED: begin
                mul_data       = req_data[int'(gnt_r)*DATA_W +: DATA_W];
                mul_stb        = req_stb[gnt_r];
                req_ack[gnt_r] = mul_ack;
                if (req_stb[gnt_r] && mul_ack) begin
                    if ((k_r + CNT_W'(1)) == cnt_r) begin
                        k_s     = '0;
                        state_s = WAIT_Z;
                    end else begin
                        k_s = k_r + CNT_W'(1);
                    end
                end else begin
                    k_s = k_r;
                end
            end
            WAIT_Z: begin
                if (mul_z_stb) begin
                    res_data_s = mul_z;
                    res_id_s   = gnt_r;
                    state_s    = OUT;
                end else begin
                    state_s = WAIT_Z;
                end
            end
            OUT: begin
                if (res_ack) begin
                    last_s  = gnt_r;
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any product in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            last_r     <= ID_W'(N_REQ - 1);
            cnt_r      <= '0;
            k_r        <= '0;
            cnt_max_r  <= '0;
            res_data_r <= '0;
            res_id_r   <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            last_r     <= last_s;
            cnt_r      <= cnt_s;
            k_r        <= k_s;
            cnt_max_r  <= cnt_max_s;
            res_data_r <= res_data_s;
            res_id_r   <= res_id_s;
        end
    end

    assign mul_cnt_max = cnt_max_r;
    assign res_data    = res_data_r;
    assign res_id      = res_id_r;
    assign mul_z_ack   = (state_r == WAIT_Z);
    assign res_stb     = (state_r == OUT);
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_mul_node_sched.sv
// Directed bench for mul_node_sched with behavioural requesters and a behavioural mul_one.
module tb_mul_node_sched;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_stb;
    logic [N-1:0]  req_ack;
    logic [N*3-1:0] req_cnt;
    logic [31:0]   mul_data;
    logic          mul_stb;
    logic          mul_ack = 1'b1;
    logic [2:0]    mul_cnt_max;
    logic [31:0]   mul_z;
    logic          mul_z_stb;
    logic          mul_z_ack;
    logic [31:0]   res_data;
    logic [1:0]    res_id;
    logic          res_stb;
    logic          res_ack = 1'b1;
    logic          busy;

    mul_node_sched #(.N_REQ(N), .ID_W(2), .CNT_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_stb(req_stb), .req_ack(req_ack), .req_cnt(req_cnt),
        .mul_data(mul_data), .mul_stb(mul_stb), .mul_ack(mul_ack), .mul_cnt_max(mul_cnt_max),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .res_data(res_data), .res_id(res_id), .res_stb(res_stb), .res_ack(res_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester state: the initial block issues requests, the monitor retires them
    logic [31:0] ops [N][8];
    logic [2:0]  cnt_tb [N];
    int          issued [N];
    int          done [N];
    int          idx [N];
    int          ack_cnt [N];
    int          nlog = 0;
    int          mul_stb_cycles = 0;
    logic [31:0] log_data [32];
    logic [1:0]  log_id [32];

    always_comb begin
        req_stb  = '0;
        req_data = '0;
        req_cnt  = '0;
        for (int i = 0; i < N; i++) begin
            req_stb[i]          = (issued[i] != done[i]) && (cnt_tb[i] == 3'd0 || idx[i] < int'(cnt_tb[i]));
            req_data[i*32 +: 32] = ops[i][idx[i] % 8];
            req_cnt[i*3 +: 3]    = cnt_tb[i];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) idx[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_stb[i] && req_ack[i]) begin
                    idx[i]     <= idx[i] + 1;
                    ack_cnt[i] <= ack_cnt[i] + 1;
                end
            end
            if (mul_stb) mul_stb_cycles <= mul_stb_cycles + 1;
            if (res_stb && res_ack) begin
                done[res_id]   <= done[res_id] + 1;
                idx[res_id]    <= 0;
                log_data[nlog] <= res_data;
                log_id[nlog]   <= res_id;
                nlog           <= nlog + 1;
            end
        end
    end

    // Single-precision multiply for normal operands, truncating
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Behavioural mul_one: accumulates mul_cnt_max operands then offers the product
    logic [31:0] acc;
    logic [2:0]  got;
    logic        z_stb;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= 32'h3F80_0000;
            got   <= 3'd0;
            z_stb <= 1'b0;
        end else begin
            if (mul_stb && mul_ack) begin
                acc <= fmul(acc, mul_data);
                if (got + 3'd1 == mul_cnt_max) begin
                    got   <= 3'd0;
                    z_stb <= 1'b1;
                end else begin
                    got <= got + 3'd1;
                end
            end
            if (z_stb && mul_z_ack) begin
                z_stb <= 1'b0;
                acc   <= 32'h3F80_0000;
            end
        end
    end
    assign mul_z     = acc;
    assign mul_z_stb = z_stb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 200 && nlog < n; t++) @(negedge clk);
        check("result_timeout", 32'(nlog >= n), 32'd1);
    endtask

    initial begin
        int base;
        int b0;
        logic stall_ok;
        for (int i = 0; i < N; i++) begin
            issued[i] = 0; done[i] = 0; ack_cnt[i] = 0; cnt_tb[i] = 3'd0;
            for (int j = 0; j < 8; j++) ops[i][j] = 32'h0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_mul_stb", 32'(mul_stb), 32'd0);
        check("rst_z_ack",   32'(mul_z_ack), 32'd0);
        check("rst_res_stb", 32'(res_stb), 32'd0);
        check("rst_cnt_max", 32'(mul_cnt_max), 32'd0);
        check("rst_res",     {res_data[29:0], res_id}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: requester 1, 2*3*4 = 24
        ops[1][0] = 32'h4000_0000; ops[1][1] = 32'h4040_0000; ops[1][2] = 32'h4080_0000;
        cnt_tb[1] = 3'd3;
        issued[1]++;
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cnt_max", 32'(mul_cnt_max), 32'd3);
        wait_results(1);
        check("t1_data", log_data[0], 32'h41C0_0000);
        check("t1_id", 32'(log_id[0]), 32'd1);
        check("t1_acks", ack_cnt[1], 32'd3);
        check("t1_idle", 32'(busy), 32'd0);

        // 3: empty product from requester 3
        base = mul_stb_cycles;
        cnt_tb[3] = 3'd0;
        issued[3]++;
        @(negedge clk);
        check("t3_res_stb", 32'(res_stb), 32'd1);
        check("t3_data", res_data, 32'h3F80_0000);
        check("t3_id", 32'(res_id), 32'd3);
        wait_results(2);
        check("t3_no_mul_stb", mul_stb_cycles - base, 32'd0);

        // 2: requesters 0 (twice) and 2 -> order 0, 2, 0
        ops[0][0] = 32'h3FC0_0000; ops[0][1] = 32'h4000_0000; cnt_tb[0] = 3'd2;
        ops[2][0] = 32'h4040_0000; ops[2][1] = 32'h3F00_0000; cnt_tb[2] = 3'd2;
        issued[0] += 2;
        issued[2]++;
        wait_results(5);
        check("t2_id0", 32'(log_id[2]), 32'd0);
        check("t2_id1", 32'(log_id[3]), 32'd2);
        check("t2_id2", 32'(log_id[4]), 32'd0);
        check("t2_data0", log_data[2], 32'h4040_0000);
        check("t2_data1", log_data[3], 32'h3FC0_0000);
        check("t2_data2", log_data[4], 32'h4040_0000);

        // 4: operand backpressure, then result backpressure with requester 1 pending
        ops[0][0] = 32'h4000_0000; ops[0][1] = 32'h4040_0000; ops[0][2] = 32'h4080_0000;
        cnt_tb[0] = 3'd3;
        b0 = ack_cnt[0];
        issued[0]++;
        for (int t = 0; t < 50 && ack_cnt[0] != b0 + 1; t++) @(negedge clk);
        check("t4_first_word", ack_cnt[0] - b0, 32'd1);
        mul_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t4_stall", {29'd0, req_ack[0], mul_stb, mul_data == 32'h4040_0000}, 32'd3);
        end
        check("t4_k_hold", ack_cnt[0] - b0, 32'd1);
        res_ack = 1'b0;
        cnt_tb[1] = 3'd1;
        issued[1]++;
        mul_ack = 1'b1;
        for (int t = 0; t < 50 && !res_stb; t++) @(negedge clk);
        stall_ok = 1'b1;
        repeat (10) begin
            stall_ok &= res_stb && (res_id == 2'd0) && (res_data == 32'h41C0_0000)
                        && (req_ack == 4'd0) && (mul_cnt_max == 3'd3);
            @(negedge clk);
        end
        check("t4_out_stall", 32'(stall_ok), 32'd1);
        check("t4_no_log", nlog, 32'd5);
        res_ack = 1'b1;
        wait_results(7);
        check("t4_id0", 32'(log_id[5]), 32'd0);
        check("t4_data0", log_data[5], 32'h41C0_0000);
        check("t4_id1", 32'(log_id[6]), 32'd1);
        check("t4_data1", log_data[6], 32'h4000_0000);

        // 5: reset mid-FEED of requester 2, requester 0 also pending
        ops[2][0] = 32'h4000_0000; ops[2][1] = 32'h4040_0000; ops[2][2] = 32'h4080_0000;
        cnt_tb[2] = 3'd3;
        b0 = ack_cnt[2];
        issued[2]++;
        for (int t = 0; t < 50 && ack_cnt[2] != b0 + 1; t++) @(negedge clk);
        check("t5_first_word", ack_cnt[2] - b0, 32'd1);
        cnt_tb[0] = 3'd1;
        issued[0]++;
        rst = 1'b0;
        #1;
        check("t5_async_rst", {27'd0, busy, mul_stb, res_stb, mul_z_ack, |req_ack}, 32'd0);
        check("t5_async_cnt", 32'(mul_cnt_max), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_results(9);
        check("t5_first_id", 32'(log_id[7]), 32'd0);
        check("t5_first_data", log_data[7], 32'h4000_0000);
        check("t5_second_id", 32'(log_id[8]), 32'd2);
        check("t5_second_data", log_data[8], 32'h41C0_0000);

        // 6: requester 2 arrives while requester 0 waits for its result
        cnt_tb[0] = 3'd1;
        issued[0]++;
        for (int t = 0; t < 50 && !mul_z_ack; t++) @(negedge clk);
        check("t6_wait_z", 32'(mul_z_ack), 32'd1);
        cnt_tb[2] = 3'd1;
        issued[2]++;
        @(negedge clk);
        check("t6_not_granted", {30'd0, req_ack[2], res_stb}, 32'd1);
        wait_results(11);
        check("t6_id0", 32'(log_id[9]), 32'd0);
        check("t6_id1", 32'(log_id[10]), 32'd2);
        check("t6_data1", log_data[10], 32'h4000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_node_sched.md
Name: mul_node_sched

Overview:
- Round-robin scheduler that shares one mul_one multiply node among N_REQ product-node requesters.
- A requester is granted exclusive use of the multiplier. It streams its operands into the multiplier, and the scheduler routes the single result back to the output channel tagged with the requester id.
- Sits between the operand producers (file readers / upstream sum nodes) and mul_one. It programs mul_one's cnt_max per grant.
- All channels use stb/ack handshakes. A word transfers in any cycle where stb and ack are both 1.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must satisfy 2**ID_W >= N_REQ
CNT_W, 3, operand-count width, matches mul_one cnt_max
DATA_W, 32, IEEE-754 single word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_data  in  N_REQ*DATA_W  operand word per requester, slice i = requester i
req_stb  in  N_REQ  operand valid per requester
req_ack  out  N_REQ  operand accepted per requester
req_cnt  in  N_REQ*CNT_W  operand count of requester i's product; sampled at grant
mul_data  out  DATA_W  operand to mul_one
mul_stb  out  1  operand valid to mul_one
mul_ack  in  1  mul_one accepts operand
mul_cnt_max  out  CNT_W  operand count for current product
mul_z  in  DATA_W  mul_one result
mul_z_stb  in  1  result valid
mul_z_ack  out  1  result accepted
res_data  out  DATA_W  product result
res_id  out  ID_W  requester that owns res_data
res_stb  out  1  result valid
res_ack  in  1  downstream accepts result
busy  out  1  1 in every state except IDLE

Behaviour:
Reset (rst=0, async):
- state=IDLE; all req_ack=0; mul_stb=0; mul_z_ack=0; res_stb=0.
- mul_data=0; mul_cnt_max=0; res_data=0; res_id=0; busy=0.
- Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation aborts the product immediately. No partial result is emitted.

States: IDLE, FEED, WAIT_Z, OUT.

IDLE:
- If any req_stb=1, grant g = first i with req_stb[i]=1, searching from (last+1) mod N_REQ upward with wrap.
- Latch g and cnt=req_cnt[g]; mul_cnt_max<=req_cnt[g].
- If cnt != 0: next state FEED.
- If cnt == 0 (empty product): res_data<=32'h3F800000 (1.0), res_id<=g, next state OUT. mul_stb is never raised and no operand is consumed.
- Arbitration occurs only in IDLE. Requests that arrive during any other state wait.

FEED:
- Combinational pass-through, zero added latency:
  - mul_data=req_data[g]
  - mul_stb=req_stb[g]
  - req_ack[g]=mul_ack
- All other req_ack stay 0.
- Transfer counter k increments on each cycle with req_stb[g]&mul_ack.
- When k reaches cnt (on the transfer cycle), next state is WAIT_Z; mul_stb and req_ack are 0 from the following cycle.
- Requester g may drop stb between words. This stalls the product; no timeout.

WAIT_Z:
- mul_z_ack=1.
- On mul_z_stb: res_data<=mul_z, res_id<=g, next state OUT.

OUT:
- res_stb=1; res_data and res_id held stable.
- On res_ack: last<=g, next state IDLE.
- res_ack held low stalls indefinitely. No new grant is made while stalled.

Other rules:
- mul_cnt_max holds constant from grant until the return to IDLE.
- Minimum cycles for a grant (single operand, all acks high): IDLE 1 + FEED 1 + WAIT_Z ≥1 + OUT 1.
- req_cnt changing after the grant has no effect on the current product.
- Requesters with stb low are skipped. Pointer wrap: with last=N_REQ-1, search starts at 0.

Test Plan:
1. Requester 1 only: cnt=3, operands 0x40000000, 0x40400000, 0x40800000 (2, 3, 4); behavioural mul_one → res_data=0x41C00000 (24.0), res_id=1, exactly 3 req_ack[1] pulses, mul_cnt_max=3, busy=0 after res_ack.
2. Requesters 0 and 2 pending with cnt=2; requester 0 re-requests immediately after its result → grant order 0, 2, 0. Requester 2 is not starved.
3. Requester 3 with cnt=0 → res_data=0x3F800000, res_id=3 within 2 cycles; mul_stb never 1.
4. Backpressure: mul_ack=0 for 4 cycles mid-FEED → req_ack[g]=0 throughout, k unchanged, words unchanged. res_ack held 0 for 10 cycles with requester 1 pending → res_stb stays 1, requester 1 not granted until after res_ack.
5. rst=0 pulse mid-FEED after 1 of 3 operands → all outputs at reset values asynchronously (same cycle). After release, first grant goes to requester 0 if pending. No stale result appears.
6. Requester 2 raises stb during WAIT_Z of requester 0's product → requester 2 is not granted until requester 0's result completes; then it is granted.
